// File: rtl/usb_fifo_pkg.sv
// usb_fifo_pkg: shared word width and word type for the USB FIFO bridge
package usb_fifo_pkg;
  localparam int USB_DATA_W = 16;
  typedef logic [USB_DATA_W-1:0] usb_word_t;
endpackage

// File: rtl/usb_skid_buf2.sv
// usb_skid_buf2: 2-entry FIFO exposing the oldest entry and next occupancy
module usb_skid_buf2 import usb_fifo_pkg::*; #(
  parameter int W = USB_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ,
  output logic [1:0]   occ_next
);
  logic [W-1:0] tail;
  assign occ_next = occ + {1'b0, push} - {1'b0, pop};
  // head always holds the oldest word; tail only fills when both slots are used
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      occ <= occ_next;
      if (pop ? (occ == 2'd2 || push) : (push && occ == 2'd0))
        head <= (pop && occ == 2'd2) ? tail : push_data;
      if (push && occ_next == 2'd2)
        tail <= push_data;
    end
  end
endmodule

// File: rtl/usb_fifo_stream_bridge.sv
// usb_fifo_stream_bridge: Avalon-MM USB FIFO masters to valid/ready streams with counters and stall flags
module usb_fifo_stream_bridge import usb_fifo_pkg::*; #(
  parameter int DATA_W      = USB_DATA_W,
  parameter int CNT_W       = 32,
  parameter int STALL_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] usb_read_data,
  input  logic              usb_read_wait,
  output logic              usb_read_en,
  output logic [DATA_W-1:0] usb_write_data,
  input  logic              usb_write_wait,
  output logic              usb_write_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  tx_count,
  output logic              rd_stall,
  output logic              wr_stall,
  input  logic              clr_stall
);
  localparam logic [15:0] LIM = 16'(STALL_LIMIT - 1);
  logic       rd_done, wr_done, rx_pop;
  logic [1:0] occ, occ_next, st_req, st_wait, st_flag;
  assign rd_done  = usb_read_en && !usb_read_wait;
  assign wr_done  = usb_write_en && !usb_write_wait;
  assign tx_ready = !usb_write_en || !usb_write_wait;
  assign rx_valid = occ != 2'd0;
  assign rx_pop   = rx_valid && rx_ready;
  assign st_req   = {usb_write_en, usb_read_en};
  assign st_wait  = {usb_write_wait, usb_read_wait};
  assign rd_stall = st_flag[0];
  assign wr_stall = st_flag[1];
  usb_skid_buf2 #(.W(DATA_W)) u_skid (
    .clk(clk), .rst(rst), .push(rd_done), .push_data(usb_read_data), .pop(rx_pop),
    .head(rx_data), .occ(occ), .occ_next(occ_next)
  );
  // hold a pending read, otherwise request only if the buffer will have room
  always_ff @(posedge clk or posedge rst) begin
    if (rst) usb_read_en <= 1'b0;
    else usb_read_en <= (usb_read_en && usb_read_wait) || occ_next < 2'd2;
  end
  // one-word write holding register, refilled in the cycle it drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      usb_write_en   <= 1'b0;
      usb_write_data <= '0;
    end else if (tx_valid && tx_ready) begin
      usb_write_en   <= 1'b1;
      usb_write_data <= tx_data;
    end else if (wr_done) begin
      usb_write_en <= 1'b0;
    end
  end
  // completed-transfer counters, wrapping silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count <= '0;
      tx_count <= '0;
    end else begin
      rx_count <= rx_count + CNT_W'(rd_done);
      tx_count <= tx_count + CNT_W'(wr_done);
    end
  end
  for (genvar i = 0; i < 2; i++) begin : g_stall
    logic [15:0] cnt;
    logic        flag;
    assign st_flag[i] = flag;
    // count consecutive stalled cycles; clear beats a same-cycle stall event
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt  <= '0;
        flag <= 1'b0;
      end else if (clr_stall) begin
        cnt  <= '0;
        flag <= 1'b0;
      end else if (st_req[i] && st_wait[i]) begin
        if (cnt == LIM) flag <= 1'b1;
        else cnt <= cnt + 16'd1;
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_usb_fifo_stream_bridge.sv
// tb_usb_fifo_stream_bridge: table-driven and directed checks of the USB FIFO stream bridge
module tb_usb_fifo_stream_bridge;
  import usb_fifo_pkg::*;
  logic clk = 0, rst = 1;
  usb_word_t usb_read_data, usb_write_data, rx_data, tx_data;
  logic usb_read_wait, usb_read_en, usb_write_wait, usb_write_en;
  logic rx_valid, rx_ready, tx_valid, tx_ready, rd_stall, wr_stall, clr_stall;
  logic [3:0] rx_count, tx_count;
  int checks = 0, failures = 0;
  usb_word_t rd_word;

  usb_fifo_stream_bridge #(.DATA_W(16), .CNT_W(4), .STALL_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .usb_read_data(usb_read_data), .usb_read_wait(usb_read_wait),
    .usb_read_en(usb_read_en), .usb_write_data(usb_write_data), .usb_write_wait(usb_write_wait),
    .usb_write_en(usb_write_en), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_count(rx_count),
    .tx_count(tx_count), .rd_stall(rd_stall), .wr_stall(wr_stall), .clr_stall(clr_stall)
  );

  always #5 clk = ~clk;

  // USB read FIFO model: supplies 1, 2, 3, ... one word per completed read
  always @(posedge clk or posedge rst) begin
    if (rst) rd_word <= 16'd1;
    else if (usb_read_en && !usb_read_wait) rd_word <= rd_word + 16'd1;
  end
  assign usb_read_data = rd_word;

  // skid buffer must never be pushed while full unless it is also popped
  always @(posedge clk) begin
    if (!rst && dut.u_skid.push) begin
      checks++;
      if (dut.u_skid.occ == 2'd2 && !dut.u_skid.pop) begin
        failures++;
        $display("FAIL overflow: push at occupancy %0d without pop", dut.u_skid.occ);
      end
    end
  end

  typedef struct {
    bit rst_before, rd_wait, rx_ready, tx_valid;
    logic [15:0] tx_data;
    bit wr_wait;
    bit e_ren, e_rxv;
    logic [15:0] e_rxd;
    logic [3:0] e_rxc;
    bit e_wen;
    logic [15:0] e_wd;
    bit e_txr;
    logic [3:0] e_txc;
    bit e_rds;
  } vec_t;
  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    usb_read_wait = 1; usb_write_wait = 0; rx_ready = 0; tx_valid = 0; tx_data = '0; clr_stall = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic run_rows(input int a, input int b);
    for (int i = a; i < b; i++) begin
      if (vecs[i].rst_before) do_reset();
      usb_read_wait = vecs[i].rd_wait; rx_ready = vecs[i].rx_ready;
      tx_valid = vecs[i].tx_valid; tx_data = vecs[i].tx_data; usb_write_wait = vecs[i].wr_wait;
      #1;
      chk($sformatf("row%0d read_en", i), 32'(usb_read_en), 32'(vecs[i].e_ren));
      chk($sformatf("row%0d rx_valid", i), 32'(rx_valid), 32'(vecs[i].e_rxv));
      chk($sformatf("row%0d rx_data", i), 32'(rx_data), 32'(vecs[i].e_rxd));
      chk($sformatf("row%0d rx_count", i), 32'(rx_count), 32'(vecs[i].e_rxc));
      chk($sformatf("row%0d write_en", i), 32'(usb_write_en), 32'(vecs[i].e_wen));
      chk($sformatf("row%0d write_data", i), 32'(usb_write_data), 32'(vecs[i].e_wd));
      chk($sformatf("row%0d tx_ready", i), 32'(tx_ready), 32'(vecs[i].e_txr));
      chk($sformatf("row%0d tx_count", i), 32'(tx_count), 32'(vecs[i].e_txc));
      chk($sformatf("row%0d rd_stall", i), 32'(rd_stall), 32'(vecs[i].e_rds));
      @(negedge clk);
    end
  endtask

  initial begin
    usb_word_t exp_word;
    //          rb rw rr tv tx_data  ww | ren rxv rxd   rxc wen wd       txr txc rds
    vecs[0]  = '{1, 0, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 16'h0000, 0,  1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 16'h0000, 0,  1, 1, 16'h0001, 1, 0, 16'h0000, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 16'h0000, 0,  0, 1, 16'h0001, 2, 0, 16'h0000, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 16'h0000, 0,  0, 1, 16'h0001, 2, 0, 16'h0000, 1, 0, 0};
    vecs[5]  = '{0, 0, 1, 0, 16'h0000, 0,  0, 1, 16'h0001, 2, 0, 16'h0000, 1, 0, 0};
    vecs[6]  = '{0, 0, 1, 0, 16'h0000, 0,  1, 1, 16'h0002, 2, 0, 16'h0000, 1, 0, 0};
    vecs[7]  = '{0, 0, 1, 0, 16'h0000, 0,  1, 1, 16'h0003, 3, 0, 16'h0000, 1, 0, 0};
    vecs[8]  = '{0, 0, 1, 0, 16'h0000, 0,  1, 1, 16'h0004, 4, 0, 16'h0000, 1, 0, 0};
    vecs[9]  = '{1, 1, 0, 1, 16'hA5A5, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0};
    vecs[10] = '{0, 1, 0, 1, 16'h5A5A, 1,  1, 0, 16'h0000, 0, 1, 16'hA5A5, 0, 0, 0};
    vecs[11] = '{0, 1, 0, 1, 16'h5A5A, 1,  1, 0, 16'h0000, 0, 1, 16'hA5A5, 0, 0, 0};
    vecs[12] = '{0, 1, 0, 1, 16'h5A5A, 1,  1, 0, 16'h0000, 0, 1, 16'hA5A5, 0, 0, 0};
    vecs[13] = '{0, 1, 0, 1, 16'h5A5A, 0,  1, 0, 16'h0000, 0, 1, 16'hA5A5, 1, 0, 0};
    vecs[14] = '{0, 1, 0, 0, 16'h0000, 0,  1, 0, 16'h0000, 0, 1, 16'h5A5A, 1, 1, 1};
    vecs[15] = '{0, 1, 0, 0, 16'h0000, 0,  1, 0, 16'h0000, 0, 0, 16'h5A5A, 1, 2, 1};
    do_reset();
    #1;
    chk("reset read_en", 32'(usb_read_en), 0);
    chk("reset tx_ready", 32'(tx_ready), 1);
    chk("reset rx_valid", 32'(rx_valid), 0);
    @(negedge clk);
    run_rows(0, 9);
    exp_word = 16'd5;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("stream%0d rx_valid", i), 32'(rx_valid), 1);
      chk($sformatf("stream%0d rx_data", i), 32'(rx_data), 32'(exp_word));
      chk($sformatf("stream%0d rx_count", i), 32'(rx_count), 32'(exp_word[3:0]));
      exp_word = exp_word + 16'd1;
      @(negedge clk);
    end
    run_rows(9, 16);
    clr_stall = 1;
    #1 chk("clr pending rd_stall", 32'(rd_stall), 1);
    @(negedge clk);
    clr_stall = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("recount%0d rd_stall", i), 32'(rd_stall), 0);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("reset%0d rd_stall", i), 32'(rd_stall), 1);
      @(negedge clk);
    end
    do_reset();
    usb_read_wait = 0; tx_valid = 1; tx_data = 16'h1234; usb_write_wait = 1;
    @(negedge clk);
    tx_valid = 0;
    @(negedge clk);
    usb_read_wait = 1;
    #1;
    chk("pre-rst write_en", 32'(usb_write_en), 1);
    chk("pre-rst rx_valid", 32'(rx_valid), 1);
    chk("pre-rst rx_count", 32'(rx_count), 1);
    rst = 1;
    #1;
    chk("async write_en", 32'(usb_write_en), 0);
    chk("async rx_valid", 32'(rx_valid), 0);
    chk("async read_en", 32'(usb_read_en), 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post-rst rx_count", 32'(rx_count), 0);
    chk("post-rst tx_count", 32'(tx_count), 0);
    chk("post-rst rd_stall", 32'(rd_stall), 0);
    chk("post-rst wr_stall", 32'(wr_stall), 0);
    chk("post-rst write_data", 32'(usb_write_data), 0);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      tx_valid = 1; tx_data = 16'(i); usb_write_wait = 0;
      @(negedge clk);
    end
    tx_valid = 0;
    @(negedge clk);
    #1;
    chk("wrap tx_count", 32'(tx_count), 1);
    chk("wrap write_en", 32'(usb_write_en), 0);
    chk("wrap write_data", 32'(usb_write_data), 16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
